// File: rtl/bcd_time_counter.sv
// BCD stopwatch/timer core: cascaded per-digit time value (min:sec.ms)
// counting up or down on a 1 kHz tick, with preset load, saturate-or-wrap
// at the limits, and a lap-freeze display snapshot.
module bcd_time_counter #(
  parameter int MIN_DIGITS = 2,
  parameter bit WRAP       = 1'b0,
  localparam int W         = 4*(5+MIN_DIGITS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         enable,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_bcd,
  input  logic         down,
  input  logic         lap,
  output logic [W-1:0] count_bcd,
  output logic [W-1:0] disp_bcd,
  output logic         lap_active,
  output logic         at_limit,
  output logic         done
);

  localparam int ND = 5 + MIN_DIGITS;

  typedef enum logic {LIVE = 1'b0, FROZEN = 1'b1} lap_state_t;

  // Digit 4 is the seconds-tens digit (0..5); every other digit is 0..9.
  function automatic logic [3:0] digit_max(input int i);
    return (i == 4) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [W-1:0] max_val();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = digit_max(i);
    return r;
  endfunction

  // Ripple carry across all digits in one cycle.
  function automatic logic [W-1:0] inc_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < ND; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (d == digit_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Mirror borrow chain: a zero digit reloads to its maximum and borrows.
  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    logic [3:0]   d;
    r = v;
    b = 1'b1;
    for (int i = 0; i < ND; i++) begin
      d = v[4*i +: 4];
      if (b) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = digit_max(i);
        end else begin
          r[4*i +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Clamp out-of-range preset digits to their legal maximum.
  function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < ND; i++) begin
      if (v[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_VAL = max_val();

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] snap_q, snap_d;
  logic         done_q, done_d;
  lap_state_t   lap_state_q, lap_state_d;
  logic [W-1:0] lim_val;
  logic         step;

  assign lim_val = down ? {W{1'b0}} : MAX_VAL;
  assign at_limit = (count_q == lim_val);
  assign step = tick & enable;

  // Count next-state: clear > load > step; done only when a real step lands on the limit.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = sanitise(load_bcd);
    end else if (step) begin
      if (at_limit) begin
        if (WRAP) count_d = down ? MAX_VAL : {W{1'b0}};
      end else begin
        count_d = down ? dec_bcd(count_q) : inc_bcd(count_q);
        done_d  = ((down ? dec_bcd(count_q) : inc_bcd(count_q)) == lim_val);
      end
    end
  end

  // Lap FSM: LIVE captures the pre-update count on a lap pulse; clear forces LIVE.
  always_comb begin
    lap_state_d = lap_state_q;
    snap_d      = snap_q;
    if (clear) begin
      lap_state_d = LIVE;
      snap_d      = '0;
    end else if (lap) begin
      case (lap_state_q)
        LIVE: begin
          lap_state_d = FROZEN;
          snap_d      = count_q;
        end
        FROZEN:  lap_state_d = LIVE;
        default: lap_state_d = LIVE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      snap_q      <= '0;
      done_q      <= 1'b0;
      lap_state_q <= LIVE;
    end else begin
      count_q     <= count_d;
      snap_q      <= snap_d;
      done_q      <= done_d;
      lap_state_q <= lap_state_d;
    end
  end

  assign count_bcd  = count_q;
  assign lap_active = (lap_state_q == FROZEN);
  assign disp_bcd   = lap_active ? snap_q : count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: a vector table for single-cycle
// behaviour plus hand sequences for long counts, lap, wrap and reset.
module tb_bcd_time_counter;

  localparam int W = 28;

  logic         clk = 1'b0;
  logic         rst, tick, enable, clear, load, down, lap;
  logic [W-1:0] load_bcd;
  logic [W-1:0] c0, d0, c1, d1;
  logic         la0, al0, dn0, la1, al1, dn1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.MIN_DIGITS(2), .WRAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .clear(clear),
    .load(load), .load_bcd(load_bcd), .down(down), .lap(lap),
    .count_bcd(c0), .disp_bcd(d0), .lap_active(la0), .at_limit(al0), .done(dn0)
  );

  bcd_time_counter #(.MIN_DIGITS(2), .WRAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .clear(clear),
    .load(load), .load_bcd(load_bcd), .down(down), .lap(lap),
    .count_bcd(c1), .disp_bcd(d1), .lap_active(la1), .at_limit(al1), .done(dn1)
  );

  typedef struct {
    logic         clr, ld;
    logic [W-1:0] lbcd;
    logic         dn, lp, tk, en;
    logic [W-1:0] e_cnt, e_disp;
    logic         e_lap, e_done, e_lim;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mkv(logic clr, logic ld, logic [W-1:0] lbcd, logic dn,
                               logic lp, logic tk, logic en, logic [W-1:0] e_cnt,
                               logic [W-1:0] e_disp, logic e_lap, logic e_done,
                               logic e_lim);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lbcd = lbcd; v.dn = dn; v.lp = lp; v.tk = tk;
    v.en = en; v.e_cnt = e_cnt; v.e_disp = e_disp; v.e_lap = e_lap;
    v.e_done = e_done; v.e_lim = e_lim;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    clear = 0; load = 0; lap = 0; tick = 0; enable = 1; rst = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; tick = 0; enable = 0; clear = 0; load = 0; down = 0; lap = 0;
    load_bcd = '0;
    cyc(); cyc();

    // Reset state
    chk("rst_count", c0, 28'h0);
    chk("rst_disp", d0, 28'h0);
    chk("rst_lap", {27'd0, la0}, 28'h0);
    chk("rst_done", {27'd0, dn0}, 28'h0);
    chk("rst_atlim_up", {27'd0, al0}, 28'h0);
    down = 1; #1;
    chk("rst_atlim_dn", {27'd0, al0}, 28'h1);
    down = 0;
    rst = 0;

    //             clr ld  lbcd         dn lp tk en  e_cnt        e_disp       lap done lim
    tv.push_back(mkv(0, 0, 28'h0,       0, 0, 0, 1, 28'h0000000, 28'h0000000, 0, 0, 0));
    tv.push_back(mkv(0, 0, 28'h0,       1, 0, 0, 1, 28'h0000000, 28'h0000000, 0, 0, 1));
    tv.push_back(mkv(0, 1, 28'h9959998, 0, 0, 0, 1, 28'h9959998, 28'h9959998, 0, 0, 0));
    tv.push_back(mkv(0, 0, 28'h0,       0, 0, 1, 1, 28'h9959999, 28'h9959999, 0, 1, 1));
    tv.push_back(mkv(0, 0, 28'h0,       0, 0, 1, 1, 28'h9959999, 28'h9959999, 0, 0, 1));
    tv.push_back(mkv(0, 0, 28'h0,       0, 0, 1, 1, 28'h9959999, 28'h9959999, 0, 0, 1));
    tv.push_back(mkv(0, 1, 28'h009FAAA, 0, 0, 0, 1, 28'h0059999, 28'h0059999, 0, 0, 0));
    tv.push_back(mkv(0, 0, 28'h0,       0, 0, 1, 1, 28'h0100000, 28'h0100000, 0, 0, 0));
    tv.push_back(mkv(0, 0, 28'h0,       1, 0, 1, 1, 28'h0059999, 28'h0059999, 0, 0, 0));
    tv.push_back(mkv(0, 0, 28'h0,       1, 0, 1, 0, 28'h0059999, 28'h0059999, 0, 0, 0));
    tv.push_back(mkv(0, 1, 28'h0000001, 1, 0, 1, 1, 28'h0000001, 28'h0000001, 0, 0, 0));
    tv.push_back(mkv(0, 0, 28'h0,       1, 0, 1, 1, 28'h0000000, 28'h0000000, 0, 1, 1));
    tv.push_back(mkv(0, 0, 28'h0,       1, 0, 1, 1, 28'h0000000, 28'h0000000, 0, 0, 1));
    tv.push_back(mkv(0, 1, 28'h9959999, 0, 0, 0, 1, 28'h9959999, 28'h9959999, 0, 0, 1));
    tv.push_back(mkv(1, 0, 28'h0,       0, 0, 1, 1, 28'h0000000, 28'h0000000, 0, 0, 0));
    tv.push_back(mkv(0, 1, 28'h0005123, 0, 0, 0, 1, 28'h0005123, 28'h0005123, 0, 0, 0));
    tv.push_back(mkv(0, 0, 28'h0,       0, 1, 1, 1, 28'h0005124, 28'h0005123, 1, 0, 0));
    tv.push_back(mkv(0, 0, 28'h0,       0, 0, 1, 1, 28'h0005125, 28'h0005123, 1, 0, 0));
    tv.push_back(mkv(0, 0, 28'h0,       0, 1, 0, 1, 28'h0005125, 28'h0005125, 0, 0, 0));
    tv.push_back(mkv(0, 0, 28'h0,       0, 1, 0, 1, 28'h0005125, 28'h0005125, 1, 0, 0));
    tv.push_back(mkv(1, 0, 28'h0,       0, 1, 1, 1, 28'h0000000, 28'h0000000, 0, 0, 0));

    foreach (tv[i]) begin
      clear = tv[i].clr; load = tv[i].ld; load_bcd = tv[i].lbcd; down = tv[i].dn;
      lap = tv[i].lp; tick = tv[i].tk; enable = tv[i].en;
      cyc();
      chk($sformatf("v%0d_count", i), c0, tv[i].e_cnt);
      chk($sformatf("v%0d_disp", i), d0, tv[i].e_disp);
      chk($sformatf("v%0d_lap", i), {27'd0, la0}, {27'd0, tv[i].e_lap});
      chk($sformatf("v%0d_done", i), {27'd0, dn0}, {27'd0, tv[i].e_done});
      chk($sformatf("v%0d_atlim", i), {27'd0, al0}, {27'd0, tv[i].e_lim});
    end
    idle();

    // 1000 ticks up from reset
    begin
      int done_seen;
      done_seen = 0;
      rst = 1; down = 0; cyc(); rst = 0;
      tick = 1; enable = 1;
      for (int k = 0; k < 1000; k++) begin
        cyc();
        if (dn0) done_seen++;
      end
      tick = 0;
      chk("k1000_count", c0, 28'h0001000);
      chk("k1000_done_never", done_seen[W-1:0], 28'h0);
      chk("k1000_atlim", {27'd0, al0}, 28'h0);
    end

    // Lap freeze across 500 ticks
    load = 1; load_bcd = 28'h0005123; cyc(); load = 0;
    lap = 1; cyc(); lap = 0;
    tick = 1;
    for (int k = 0; k < 500; k++) cyc();
    tick = 0;
    chk("lap500_disp", d0, 28'h0005123);
    chk("lap500_count", c0, 28'h0005623);
    chk("lap500_active", {27'd0, la0}, 28'h1);
    lap = 1; cyc(); lap = 0;
    chk("lap_release_disp", d0, 28'h0005623);
    chk("lap_release_active", {27'd0, la0}, 28'h0);

    // Wrap instance: down through zero, then up through MAX
    load = 1; load_bcd = 28'h0000001; down = 1; cyc(); load = 0;
    chk("wrap_done_pre", {27'd0, dn1}, 28'h0);
    tick = 1; cyc();
    chk("wrap_dn_zero", c1, 28'h0000000);
    chk("wrap_dn_done", {27'd0, dn1}, 28'h1);
    cyc();
    chk("wrap_dn_max", c1, 28'h9959999);
    chk("wrap_dn_nodone", {27'd0, dn1}, 28'h0);
    down = 0; cyc();
    chk("wrap_up_zero", c1, 28'h0000000);
    chk("wrap_up_nodone", {27'd0, dn1}, 28'h0);
    tick = 0;

    // Reset mid-count while frozen
    tick = 1; cyc(); cyc(); lap = 1; cyc(); lap = 0; cyc();
    chk("pre_rst_frozen", {27'd0, la0}, 28'h1);
    rst = 1; cyc(); rst = 0; tick = 0;
    chk("midrst_count", c0, 28'h0);
    chk("midrst_disp", d0, 28'h0);
    chk("midrst_lap", {27'd0, la0}, 28'h0);
    chk("midrst_done", {27'd0, dn0}, 28'h0);
    chk("midrst_count_w", c1, 28'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Parametrised BCD stopwatch/timer core. It keeps a cascaded-digit time value (minutes : seconds : milliseconds) that counts up or down on a 1 kHz tick strobe. It supports preset load, saturate-or-wrap at the limits, and a lap-freeze display path. It replaces the divide/modulo time counter between the control FSM and the 7-segment digit decoders, and feeds the decoders directly from per-digit BCD registers.

## Interface
Parameters:
- MIN_DIGITS, 2, number of BCD minute digits (1..4); minutes range 0 .. 10^MIN_DIGITS−1
- WRAP, 0, 0 = saturate at limit; 1 = wrap around past limit
- W, 4*(5+MIN_DIGITS), derived total BCD vector width; not overridable

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle count strobe (1 kHz), qualified by enable
- enable  in  1  count enable from FSM
- clear  in  1  synchronous clear of count and lap state
- load  in  1  synchronous preset from load_bcd
- load_bcd  in  W  preset value, same packing as count_bcd
- down  in  1  0 = count up, 1 = count down
- lap  in  1  one-cycle pulse; toggles lap freeze
- count_bcd  out  W  live value; [3:0] ms ones, [7:4] ms tens, [11:8] ms hundreds, [15:12] sec ones, [19:16] sec tens (0–5), [23:20] and up are minute digits, least significant first
- disp_bcd  out  W  display value: lap snapshot when lap_active, else count_bcd
- lap_active  out  1  display frozen on snapshot
- at_limit  out  1  combinational: down ? count==0 : count==MAX
- done  out  1  one-cycle pulse when a step lands on the limit

## Operation
- MAX is all minute digits 9, sec 59, ms 999 (MIN_DIGITS=2: 99:59.999).
- Priority per cycle: rst > clear > load > step (tick & enable). Lap processing is independent (see below).
- Step up: ms ones +1, with ripple carry through digits. Each digit wraps 9→0 and carries, except sec tens, which wraps 5→0 and carries. All digits update in one cycle.
- Step down: mirror borrow chain. A digit at 0 goes to 9 and borrows, except sec tens, which goes to 5 and borrows.
- At limit with a step:
  - WRAP=0: count holds; done stays low.
  - WRAP=1: up goes MAX→0; down goes 0→MAX. done stays low on the wrap step itself.
- done = 1 for exactly the cycle in which count_bcd first shows the limit value after a step. Load or clear onto the limit never raises done.
- Load sanitisation: any digit >9 is clamped to 9; sec tens >5 is clamped to 5. Load does not change lap state.
- Lap state machine, LIVE ↔ FROZEN:
  - In LIVE, a lap pulse captures the current (pre-update) count_bcd into the snapshot register and moves to FROZEN.
  - In FROZEN, a lap pulse returns to LIVE. The snapshot is retained but unused.
  - clear or rst forces LIVE and zeroes the snapshot.
  - clear and lap in the same cycle: clear wins, giving LIVE.
- Counting continues unaffected while FROZEN.
- Changing down mid-count takes effect on the next step. No other state changes.

## Timing
- Reset values: count_bcd=0, snapshot=0, lap_active=0, done=0, disp_bcd=0. at_limit equals down after reset.
- Step latency: count_bcd updates at the clk edge sampling tick & enable = 1, so the new value is visible 1 cycle later. done is registered at the same edge.
- clear and load take effect at the next edge. They are ignored for counting in that cycle, even if tick is high.
- lap: lap_active and the snapshot update at the sampling edge. disp_bcd is a combinational mux on registers and adds no latency.
- tick asserted on consecutive cycles produces one step per cycle; no minimum spacing.
- rst mid-count or mid-FROZEN returns all state to reset values at the next edge.

## Test plan
- Reset, enable=1, down=0, 1000 ticks → count_bcd reads 00:01.000; done never set; at_limit=0.
- Load 99:59.998, WRAP=0, up, 3 ticks → 99:59.999 after tick 1 with done=1 for one cycle; ticks 2–3 hold with done=0; at_limit=1.
- WRAP=1, load 00:00.001, down, 2 ticks → 00:00.000 with done pulse, then 99:59.999 with no done.
- Count at 00:05.123, pulse lap, 500 ticks → disp_bcd=00:05.123, lap_active=1, count_bcd=00:05.623. Second lap pulse → disp_bcd=count_bcd.
- Load 00:9F.AAA (sec tens 9, ones F) → count_bcd=00:59.999; done=0.
- clear and lap together while FROZEN, tick high → count=0, lap_active=0, disp_bcd=0. Then rst during counting → all outputs 0 next cycle.
